// File: rtl/uart_cmd_parser.sv
// ASCII command-line parser between the UART FIFOs and the register bus.
// Executes "W AA DD" / "R AA" lines and replies with OK, two hex digits, or ER.
module uart_cmd_parser #(
  parameter int MAX_LINE_LEN = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_fifo_empty,
  input  logic [7:0] rx_fifo_data_out,
  output logic       rx_fifo_read_en,
  input  logic       tx_fifo_full,
  output logic [7:0] tx_fifo_data_in,
  output logic       tx_fifo_write_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       cmd_error,
  output logic       busy
);

  localparam int CNT_W = $clog2(MAX_LINE_LEN + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_DATA, S_EOL, S_DISCARD, S_EXEC, S_RDWAIT, S_ERR, S_RESP
  } state_t;

  function automatic logic is_hex(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
           (c >= 8'h61 && c <= 8'h66);
  endfunction

  function automatic logic [3:0] hex_to_nib(input logic [7:0] c);
    return (c <= 8'h39) ? 4'(c - 8'h30) :
           (c <= 8'h46) ? 4'(c - 8'h37) : 4'(c - 8'h57);
  endfunction

  function automatic logic [7:0] nib_to_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  state_t           state_q, state_d;
  logic             wr_q, wr_d;
  logic             digit_q, digit_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [31:0]      resp_q, resp_d;
  logic [1:0]       resp_idx_q, resp_idx_d;
  logic             popped_q;
  logic             we_q, we_d;
  logic             re_q, re_d;
  logic             err_q, err_d;
  logic             pop, push, is_term, is_space;
  logic [7:0]       rx;

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    digit_d    = digit_q;
    line_cnt_d = line_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    resp_d     = resp_q;
    resp_idx_d = resp_idx_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    err_d      = 1'b0;
    rx         = rx_fifo_data_out;
    is_term    = (rx == 8'h0D) || (rx == 8'h0A);
    is_space   = (rx == 8'h20);
    // A pop is never issued in back-to-back cycles so the FIFO head has time to advance.
    pop  = (state_q inside {S_IDLE, S_ADDR, S_DATA, S_EOL, S_DISCARD}) &&
           !rx_fifo_empty && !popped_q && !reset;
    push = (state_q == S_RESP) && !tx_fifo_full && !reset;

    if (pop) begin
      if (is_term) begin
        line_cnt_d = '0;
        case (state_q)
          S_ADDR, S_DATA, S_DISCARD: begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
          S_EOL: begin
            state_d = S_EXEC;
            we_d    = wr_q;
            re_d    = !wr_q;
          end
          default: ;
        endcase
      end else if (line_cnt_q == CNT_W'(MAX_LINE_LEN)) begin
        state_d = S_DISCARD;
      end else begin
        line_cnt_d = line_cnt_q + CNT_W'(1);
        if (!is_space) begin
          case (state_q)
            S_IDLE: begin
              digit_d = 1'b0;
              if (rx == 8'h57 || rx == 8'h77) begin
                state_d = S_ADDR;
                wr_d    = 1'b1;
              end else if (rx == 8'h52 || rx == 8'h72) begin
                state_d = S_ADDR;
                wr_d    = 1'b0;
              end else begin
                state_d = S_DISCARD;
              end
            end
            S_ADDR: begin
              if (is_hex(rx)) begin
                addr_d  = {addr_q[3:0], hex_to_nib(rx)};
                digit_d = !digit_q;
                if (digit_q) state_d = wr_q ? S_DATA : S_EOL;
              end else begin
                state_d = S_DISCARD;
              end
            end
            S_DATA: begin
              if (is_hex(rx)) begin
                wdata_d = {wdata_q[3:0], hex_to_nib(rx)};
                digit_d = !digit_q;
                if (digit_q) state_d = S_EOL;
              end else begin
                state_d = S_DISCARD;
              end
            end
            S_EOL:   state_d = S_DISCARD;
            default: ;
          endcase
        end
      end
    end

    // The reply is shifted out MSB-first; the head byte is always on tx_fifo_data_in.
    case (state_q)
      S_EXEC: begin
        resp_idx_d = 2'd0;
        if (wr_q) begin
          resp_d  = {8'h4F, 8'h4B, 8'h0D, 8'h0A};
          state_d = S_RESP;
        end else begin
          state_d = S_RDWAIT;
        end
      end
      S_RDWAIT: begin
        resp_idx_d = 2'd0;
        resp_d     = {nib_to_hex(reg_rdata[7:4]), nib_to_hex(reg_rdata[3:0]), 8'h0D, 8'h0A};
        state_d    = S_RESP;
      end
      S_ERR: begin
        resp_idx_d = 2'd0;
        resp_d     = {8'h45, 8'h52, 8'h0D, 8'h0A};
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (push) begin
          resp_d     = {resp_q[23:0], 8'h00};
          resp_idx_d = resp_idx_q + 2'd1;
          if (resp_idx_q == 2'd3) state_d = S_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_q       <= 1'b0;
      digit_q    <= 1'b0;
      line_cnt_q <= '0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      resp_q     <= 32'h0;
      resp_idx_q <= 2'd0;
      popped_q   <= 1'b0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      digit_q    <= digit_d;
      line_cnt_q <= line_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      resp_q     <= resp_d;
      resp_idx_q <= resp_idx_d;
      popped_q   <= pop;
      we_q       <= we_d;
      re_q       <= re_d;
      err_q      <= err_d;
    end
  end

  assign rx_fifo_read_en  = pop;
  assign tx_fifo_write_en = push;
  assign tx_fifo_data_in  = resp_q[31:24];
  assign reg_addr         = addr_q;
  assign reg_wdata        = wdata_q;
  assign reg_we           = we_q;
  assign reg_re           = re_q;
  assign cmd_error        = err_q;
  assign busy             = (state_q != S_IDLE);

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Consumes the byte stream from the UART RX FIFO, assembles ASCII command lines, and executes them as single-byte register reads and writes on a simple internal register bus. It formats each reply as ASCII and pushes it into the UART TX FIFO. It sits between the `uart` block and the design's register file, so a host terminal can peek and poke registers over the serial link.

## Interface
Parameters:
- `MAX_LINE_LEN`, default 32: maximum number of non-terminator characters in one line.

Ports:
- `clock`, in, 1: system clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `rx_fifo_empty`, in, 1: RX FIFO empty flag.
- `rx_fifo_data_out`, in, 8: RX FIFO head byte. It is valid whenever `rx_fifo_empty` is 0 (show-ahead).
- `rx_fifo_read_en`, out, 1: one-cycle pop strobe to the RX FIFO.
- `tx_fifo_full`, in, 1: TX FIFO full flag.
- `tx_fifo_data_in`, out, 8: byte to push into the TX FIFO.
- `tx_fifo_write_en`, out, 1: one-cycle push strobe to the TX FIFO.
- `reg_addr`, out, 8: register bus address.
- `reg_wdata`, out, 8: register bus write data.
- `reg_we`, out, 1: one-cycle write strobe.
- `reg_re`, out, 1: one-cycle read strobe.
- `reg_rdata`, in, 8: read data. It is valid exactly 1 cycle after `reg_re`.
- `cmd_error`, out, 1: one-cycle pulse for each rejected line.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
Command syntax:
- `W AA DD` followed by a terminator writes byte `DD` to address `AA`.
- `R AA` followed by a terminator reads address `AA`.

Character rules:
- Terminator: CR (0x0D) or LF (0x0A).
- Command letters are case-insensitive.
- Hex digits are 0-9, A-F, a-f.
- Space (0x20) is ignored everywhere, so `W1234` equals `W 12 34`.
- A terminator seen in IDLE is ignored. Empty lines and CRLF therefore produce no reply.
- Every field is exactly 2 hex digits.

Responses, always uppercase ASCII:
- Write: `OK` CR LF (0x4F 0x4B 0x0D 0x0A).
- Read: two hex digits of `reg_rdata`, then CR LF.
- Error: `ER` CR LF (0x45 0x52 0x0D 0x0A).

States:
- IDLE: `W`/`w` goes to ADDR with write flag set; `R`/`r` goes to ADDR with write flag clear; a terminator stays in IDLE; any other non-space character goes to DISCARD.
- ADDR: collects 2 hex digits into `reg_addr`, high nibble first. After the second digit it goes to DATA (write) or EOL (read). A non-hex character goes to DISCARD. A terminator goes to ERR.
- DATA: collects 2 hex digits into `reg_wdata`, then goes to EOL. Errors are handled as in ADDR.
- EOL: a terminator goes to EXEC. Any other non-space character goes to DISCARD.
- DISCARD: pops bytes until a terminator, then goes to ERR.
- EXEC: pulses `reg_we` or `reg_re` for 1 cycle. A read goes to RDWAIT; a write goes to RESP.
- RDWAIT: latches `reg_rdata` into the response buffer, then goes to RESP.
- ERR: pulses `cmd_error` for 1 cycle, loads the `ER` response, then goes to RESP.
- RESP: pushes the 4 response bytes in order, then goes to IDLE.

Line length:
- The counter counts every non-terminator character consumed since the last terminator, spaces included.
- The (MAX_LINE_LEN+1)th such character forces DISCARD from any state.
- The counter saturates and clears on the terminator.

Flow control:
- Bytes are popped only in IDLE, ADDR, DATA, EOL and DISCARD.
- No pops occur during EXEC, RDWAIT, ERR or RESP, so RX bytes queue in the FIFO.
- Nibble conversion: '0'-'9' maps to value minus 0x30; 'A'-'F' to value minus 0x37; 'a'-'f' to value minus 0x57. Output digits 0-9 map to 0x30+n; 10-15 map to 0x37+n.

## Timing
- Reset values: all outputs 0, state IDLE, line counter 0, response buffer cleared.
- Reset mid-line or mid-response abandons the operation. Bytes already pushed stay in the TX FIFO, and no further strobes occur.
- Pop rule: `rx_fifo_read_en` is asserted in cycle T only if `rx_fifo_empty`=0 and there was no pop in T-1, i.e. at most one pop every 2 cycles. The byte is sampled from `rx_fifo_data_out` in cycle T.
- Terminator popped in cycle T: EXEC is in T+1, so `reg_we`/`reg_re` is high for T+1 only.
- Write response: first `tx_fifo_write_en` no earlier than T+2.
- Read response: `reg_rdata` is sampled in T+2; first push no earlier than T+3.
- Error: `cmd_error` is high in T+1; first push no earlier than T+2.
- Push rule: in RESP, one byte is pushed per cycle while `tx_fifo_full`=0. When full, `tx_fifo_write_en` stays 0 and `tx_fifo_data_in` holds the pending byte.
- `reg_addr` and `reg_wdata` hold their values after EXEC until the next digit is collected.

## Test plan
- Feed `W3C5A` CR → one `reg_we` pulse with `reg_addr`=0x3C and `reg_wdata`=0x5A; TX receives 0x4F 0x4B 0x0D 0x0A.
- Feed `r 3c` CR LF with `reg_rdata`=0xA7 after `reg_re` → one `reg_re` pulse at address 0x3C; TX receives 0x41 0x37 0x0D 0x0A; the LF produces no reply.
- Feed `W1G22` CR, then `Q` LF, then `R1` CR → three `cmd_error` pulses, three `ER` CR LF replies, and no `reg_we` or `reg_re`.
- Feed 40 spaces, then CR, with `MAX_LINE_LEN`=32 → one error reply. A following `R00` CR is executed normally.
- Hold `tx_fifo_full`=1 for 20 cycles during a write reply → no pushes while full; after release, exactly the 4 bytes in order, none duplicated; no RX pops until RESP completes.
- Assert `reset` after `W12` has been popped, then feed `R05` CR → no write occurs; the read executes at address 0x05.
